// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-MODULUS up/down counter with parallel load and registered terminal-count pulse.
// Optional macro CNT_SATURATE_EN: hold at the count limits instead of wrapping.
module bcd_updown_counter #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [3:0]  DIGIT_MAX = 4'(MODULUS - 1);

  logic [W-1:0] cnt_next;
  logic         tc_next;

  // Next-count logic: load clipping, then a ripple carry/borrow enable chain.
  always_comb begin : next_count
    logic [DIGITS:0] chain;
    logic [3:0]      dig;
    logic            step;
    cnt_next = cnt;
    tc_next  = 1'b0;
    chain    = '0;
    dig      = '0;
    step     = 1'b0;
    if (load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = load_val[4*i +: 4];
        cnt_next[4*i +: 4] = ({1'b0, dig} >= 5'(MODULUS)) ? DIGIT_MAX : dig;
      end
    end else if (in) begin
      // chain[i] is set when every digit below i sits at the bound for this direction
      chain[0] = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = cnt[4*i +: 4];
        chain[i+1] = chain[i] & (dig == (up ? DIGIT_MAX : 4'd0));
      end
      tc_next = chain[DIGITS];
`ifdef CNT_SATURATE_EN
      step = ~chain[DIGITS];
`else
      step = 1'b1;
`endif
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = cnt[4*i +: 4];
        if (step && chain[i]) begin
          if (up) begin
            cnt_next[4*i +: 4] = (dig == DIGIT_MAX) ? 4'd0 : 4'(dig + 4'd1);
          end else begin
            cnt_next[4*i +: 4] = (dig == 4'd0) ? DIGIT_MAX : 4'(dig - 4'd1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      tc  <= tc_next;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed + random bench for bcd_updown_counter (DIGITS=2, MODULUS=10) with an integer reference model.
module tb_bcd_updown_counter;

  localparam int TOP = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] cnt;
  logic       tc;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   mv;
  logic mtc;
  int   n_assert = 0;
  int   n_fail   = 0;

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .up(up), .load(load),
    .load_val(load_val), .cnt(cnt), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference model: one edge of the counter expressed as decimal arithmetic.
  task automatic model(input logic l, input logic [7:0] lv, input logic i, input logic u);
    int hi, lo;
    if (l) begin
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      mv  = hi * 10 + lo;
      mtc = 1'b0;
    end else if (i) begin
      if (u) begin
        if (mv == TOP - 1) begin
          mtc = 1'b1;
`ifndef CNT_SATURATE_EN
          mv = 0;
`endif
        end else begin
          mv  = mv + 1;
          mtc = 1'b0;
        end
      end else begin
        if (mv == 0) begin
          mtc = 1'b1;
`ifndef CNT_SATURATE_EN
          mv = TOP - 1;
`endif
        end else begin
          mv  = mv - 1;
          mtc = 1'b0;
        end
      end
    end else begin
      mtc = 1'b0;
    end
  endtask

  task automatic check_direct(input string tag, input logic [7:0] ec, input logic et);
    n_assert++;
    assert ({cnt, tc} === {ec, et}) else begin
      n_fail++;
      $error("FAIL %s: observed cnt=%h tc=%b expected cnt=%h tc=%b", tag, cnt, tc, ec, et);
    end
  endtask

  task automatic step(input string tag, input logic l, input logic [7:0] lv,
                      input logic i, input logic u);
    exp_t e;
    load = l; load_val = lv; in = i; up = u;
    model(l, lv, i, u);
    exp_q.push_back('{cnt: to_bcd(mv), tc: mtc});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_direct(tag, e.cnt, e.tc);
    end
  endtask

  initial begin
    rst_n = 1'b0; in = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    mv = 0; mtc = 1'b0;
    #12;
    check_direct("reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up sweep through the full range and wrap
    for (int k = 0; k < 100; k++) step("up_sweep", 1'b0, 8'h00, 1'b1, 1'b1);
    step("up_after_wrap_hold", 1'b0, 8'h00, 1'b0, 1'b1);

    // Async reset mid-cycle
    for (int k = 0; k < 37; k++) step("count_to_37", 1'b0, 8'h00, 1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_direct("async_reset", 8'h00, 1'b0);
    mv = 0; mtc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("resume_after_reset", 1'b0, 8'h00, 1'b1, 1'b1);

    // Borrow and down wrap
    step("load_10", 1'b1, 8'h10, 1'b0, 1'b0);
    step("down_borrow", 1'b0, 8'h00, 1'b1, 1'b0);
    step("load_00", 1'b1, 8'h00, 1'b1, 1'b0);
    step("down_wrap", 1'b0, 8'h00, 1'b1, 1'b0);
    step("down_wrap_tc_clear", 1'b0, 8'h00, 1'b0, 1'b0);

    // Load clipping overrides counting
    step("load_clip_5F", 1'b1, 8'h5F, 1'b1, 1'b1);
    step("load_clip_AF", 1'b1, 8'hAF, 1'b1, 1'b0);
    step("load_clip_F3", 1'b1, 8'hF3, 1'b0, 1'b1);

    // Hold and direction changes
    step("load_42", 1'b1, 8'h42, 1'b0, 1'b0);
    step("dir_up", 1'b0, 8'h00, 1'b1, 1'b1);
    step("dir_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    step("dir_down", 1'b0, 8'h00, 1'b1, 1'b0);
    step("dir_up2", 1'b0, 8'h00, 1'b1, 1'b1);

    // Behaviour at the limits (wrap or saturate depending on build)
    step("load_98", 1'b1, 8'h98, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step("limit_up", 1'b0, 8'h00, 1'b1, 1'b1);
    step("load_01", 1'b1, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step("limit_down", 1'b0, 8'h00, 1'b1, 1'b0);
    step("load_at_limit", 1'b1, 8'h99, 1'b1, 1'b1);

    // Random mix
    for (int k = 0; k < 300; k++) begin
      step("random", ($urandom_range(0, 15) == 0), 8'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
